// File: rtl/spi_mul_ctrl_pkg.sv
// Shared types and constants for the SPI-driven multiplier controller.
// Frame layout: [15:12] opcode, [11:8] ignored, [7:0] data.
package spi_mul_ctrl_pkg;

    localparam int FRAME_W = 16;
    localparam int OPC_W   = 4;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 16;
    localparam int CNT_W   = 8;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Status word bit positions; the low CNT_W bits carry the event counter
    localparam int ST_DONE_BIT = 15;
    localparam int ST_DROP_BIT = 14;
    localparam int ST_ERR_BIT  = 13;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP         = 4'h0,
        OP_WRITE_A     = 4'h1,
        OP_WRITE_B     = 4'h2,
        OP_START       = 4'h3,
        OP_READ_RESULT = 4'h4,
        OP_READ_STATUS = 4'h5
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_TX_ARM   = 2'd3
    } state_e;

    // Assemble the status word from the sticky flags and the counter value
    function automatic logic [FRAME_W-1:0] status_word(
        input logic             done,
        input logic             drop,
        input logic             err,
        input logic [CNT_W-1:0] cnt
    );
        logic [FRAME_W-1:0] w;
        w              = '0;
        w[ST_DONE_BIT] = done;
        w[ST_DROP_BIT] = drop;
        w[ST_ERR_BIT]  = err;
        w[CNT_W-1:0]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/spi_mul_ctrl.sv
// SPI command decoder driving an external 8x8 multiplier.
// Frames arrive from an SPI slave, are decoded one at a time, and replies
// are armed back into the slave's transmit register.
// Optional feature: define SPI_MUL_CTRL_ERRCNT_EN to add an 8-bit
// saturating counter of illegal opcodes and dropped frames (status[7:0]).
module spi_mul_ctrl
    import spi_mul_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [FRAME_W-1:0] mosi_reg_data,
    input  logic               tx_done,
    output logic               spi_start,
    output logic [FRAME_W-1:0] miso_reg_data,
    output logic               mul_start,
    output logic [DATA_W-1:0]  mul_a,
    output logic [DATA_W-1:0]  mul_b,
    input  logic               mul_done,
    input  logic [RES_W-1:0]   mul_result,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
    logic               err_q, err_d;
    logic               spi_start_d;
    logic               mul_start_d;
    logic [FRAME_W-1:0] miso_d;
    logic [DATA_W-1:0]  mul_a_d, mul_b_d;
    logic [CNT_W-1:0]   cnt_val;

    // Per-cycle events feeding the sticky flags and the optional counter
    logic               illegal_evt;
    logic               drop_evt;
    logic               status_rd;

    assign busy = (state_q != ST_IDLE);

    // Next-state and next-output decode; everything defaults to hold
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        result_d    = result_q;
        done_d      = done_q;
        drop_d      = drop_q;
        err_d       = err_q;
        spi_start_d = spi_start;
        mul_start_d = 1'b0;
        miso_d      = miso_reg_data;
        mul_a_d     = mul_a;
        mul_b_d     = mul_b;
        illegal_evt = 1'b0;
        drop_evt    = 1'b0;
        status_rd   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    op_d    = mosi_reg_data[OPC_MSB:OPC_LSB];
                    data_d  = mosi_reg_data[DATA_MSB:DATA_LSB];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op_q)
                    OP_NOP: state_d = ST_IDLE;
                    OP_WRITE_A: begin
                        mul_a_d = data_q;
                        done_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                    OP_WRITE_B: begin
                        mul_b_d = data_q;
                        done_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                    OP_START: begin
                        mul_start_d = 1'b1;
                        done_d      = 1'b0;
                        state_d     = ST_MUL_WAIT;
                    end
                    OP_READ_RESULT: begin
                        miso_d      = result_q;
                        spi_start_d = 1'b1;
                        state_d     = ST_TX_ARM;
                    end
                    OP_READ_STATUS: begin
                        miso_d      = status_word(done_q, drop_q, err_q, cnt_val);
                        status_rd   = 1'b1;
                        spi_start_d = 1'b1;
                        state_d     = ST_TX_ARM;
                    end
                    default: begin
                        illegal_evt = 1'b1;
                        state_d     = ST_IDLE;
                    end
                endcase
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    result_d = mul_result;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_TX_ARM: begin
                if (tx_done) begin
                    spi_start_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Only IDLE accepts frames; anything arriving while busy is lost
        drop_evt = rx_valid && (state_q != ST_IDLE);

        // A status read snapshots then clears; events in the same cycle
        // happened after the snapshot, so they re-set the flags
        if (status_rd) begin
            drop_d = 1'b0;
            err_d  = 1'b0;
        end
        if (illegal_evt) err_d  = 1'b1;
        if (drop_evt)    drop_d = 1'b1;
    end

`ifdef SPI_MUL_CTRL_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [CNT_W:0]   cnt_sum;

    // Saturating event counter; both events may land in one cycle
    always_comb begin
        cnt_base = status_rd ? '0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base}
                 + {{CNT_W{1'b0}}, illegal_evt}
                 + {{CNT_W{1'b0}}, drop_evt};
        cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_val = cnt_q;
`else
    assign cnt_val = '0;
`endif

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            data_q        <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
            spi_start     <= 1'b0;
            mul_start     <= 1'b0;
            miso_reg_data <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            data_q        <= data_d;
            result_q      <= result_d;
            done_q        <= done_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
            spi_start     <= spi_start_d;
            mul_start     <= mul_start_d;
            miso_reg_data <= miso_d;
            mul_a         <= mul_a_d;
            mul_b         <= mul_b_d;
        end
    end

endmodule

// File: doc/spi_mul_ctrl.md
SPI_MUL_CTRL -- requirements
Module: spi_mul_ctrl

Interface
REQ-001 SHALL have clk, input, 1, single system clock; all logic on the rising edge.
REQ-002 SHALL have reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have rx_valid, input, 1, one-cycle pulse from the SPI slave when a received frame is ready.
REQ-004 SHALL have mosi_reg_data, input, 16, received frame; valid while rx_valid=1.
REQ-005 SHALL have tx_done, input, 1, SPI slave has shifted out miso_reg_data.
REQ-006 SHALL have spi_start, output, 1, arms the SPI slave transmit.
REQ-007 SHALL have miso_reg_data, output, 16, word that the SPI slave transmits.
REQ-008 SHALL have mul_start, output, 1, one-cycle multiplier launch pulse.
REQ-009 SHALL have mul_a and mul_b, output, 8 each, multiplier operands.
REQ-010 SHALL have mul_done, input, 1, one-cycle pulse meaning mul_result is valid.
REQ-011 SHALL have mul_result, input, 16, product.
REQ-012 SHALL have busy, output, 1, high in every state except IDLE.

Function
REQ-013 Frame format SHALL be: [15:12] opcode, [11:8] ignored, [7:0] data.
REQ-014 Opcodes SHALL be:
- 0x0 NOP
- 0x1 WRITE_A
- 0x2 WRITE_B
- 0x3 START
- 0x4 READ_RESULT
- 0x5 READ_STATUS
- anything else is illegal.
REQ-015 FSM states SHALL be IDLE, DECODE, MUL_WAIT and TX_ARM.
REQ-016 Frame capture: in IDLE with rx_valid at cycle N, capture the frame and go to DECODE at N+1; actions take effect at N+2.
REQ-017 WRITE_A and WRITE_B SHALL update mul_a or mul_b from data at N+2, clear done, and return to IDLE.
REQ-018 START SHALL drive mul_start high for exactly cycle N+2, clear done, and enter MUL_WAIT.
REQ-019 In MUL_WAIT, on mul_done: latch result_q, set done, and return to IDLE on the next cycle.
REQ-020 READ_RESULT SHALL load miso_reg_data with result_q and raise spi_start at N+2, then enter TX_ARM.
REQ-021 READ_STATUS SHALL load miso_reg_data with {done, drop, err, 5'b0, cnt[7:0]}, clear drop and err in the same cycle, and enter TX_ARM.
REQ-022 In TX_ARM, spi_start SHALL hold high until tx_done; in the tx_done cycle drop spi_start and return to IDLE.
REQ-023 miso_reg_data SHALL hold its value until the next load.
REQ-024 NOP SHALL return to IDLE with no other effect.
REQ-025 An illegal opcode SHALL set the sticky err flag and return to IDLE.
REQ-026 rx_valid in any state other than IDLE SHALL discard the frame and set the sticky drop flag.
REQ-027 Simultaneous rx_valid and mul_done in MUL_WAIT SHALL both capture the result and drop the frame.
REQ-028 tx_done outside TX_ARM SHALL be ignored.
REQ-029 READ_RESULT before any multiply SHALL return 0x0000.

Reset
REQ-030 Reset SHALL set the FSM to IDLE and clear to 0: spi_start, mul_start, miso_reg_data, mul_a, mul_b, result_q, done, drop, err and cnt.
REQ-031 Reset asserted mid-operation (MUL_WAIT or TX_ARM) SHALL abort with outputs 0 on the next cycle; a later mul_done or tx_done SHALL be ignored in IDLE.

Configuration
REQ-032 With SPI_MUL_CTRL_ERRCNT_EN defined, cnt SHALL be an 8-bit counter that increments, saturating at 0xFF, on each illegal opcode or dropped frame, and clears on READ_STATUS.
REQ-033 Without SPI_MUL_CTRL_ERRCNT_EN, there SHALL be no counter and status[7:0] SHALL read 0.

Structure
REQ-034 Package spi_mul_ctrl_pkg SHALL hold the opcode enum, state enum, status bit-position constants and the frame field widths.
REQ-035 The block SHALL have no sub-module; it is a single FSM.

Verification
REQ-036 Frames 0x1007, 0x2009, 0x3000 with mul_done returning 0x003F, then 0x4000 -> mul_a=0x07, mul_b=0x09, mul_start high exactly one cycle, miso_reg_data=0x003F with spi_start held until tx_done.
REQ-037 Frame 0x9000, then 0x5000 -> miso_reg_data=0x2001 with the macro (0x2000 without it); a following 0x5000 returns 0x0000 for err and cnt.
REQ-038 START, then rx_valid with 0x1055 before mul_done -> mul_a unchanged and drop set; status after completion = 0xC001 (macro on).
REQ-039 rx_valid coincident with mul_done -> result latched, frame dropped, done=1.
REQ-040 Reset pulsed during TX_ARM -> spi_start=0 and miso_reg_data=0 the next cycle; a late tx_done is ignored and the next frame is accepted normally.
REQ-041 260 illegal frames (macro on) -> cnt saturates at 0xFF.
